// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter: the mode encodings,
// the legal parameter limits and a helper for the widest count a given width holds.
package updown_mod_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 32;
  localparam int MAX_VAL_MIN  = 1;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 65535;

  // Largest value representable in w bits, computed at 64 bits so w=32 is safe.
  function automatic longint unsigned max_count_limit(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// Enable-qualified cycle divider: raises tick on the enabled cycle that
// completes a group of PRESCALE enabled cycles, then starts a new group.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_p0;

  assign tick = en && (pcnt_p0 == LAST);

  // Count enabled cycles; clr or a completed group restarts the count at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_p0 <= '0;
    end else if (clr) begin
      pcnt_p0 <= '0;
    end else if (en) begin
      pcnt_p0 <= tick ? '0 : pcnt_p0 + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the bounds,
// a prescaled count enable, a one-cycle terminal-count pulse and a sticky
// bound-crossing flag.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = MODE_WRAP,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             counten,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("updown_mod_counter: WIDTH out of range");
  end
  if (MAX_VAL < longint'(MAX_VAL_MIN) || MAX_VAL > max_count_limit(WIDTH)) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL out of range");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_presc
    $error("updown_mod_counter: PRESCALE out of range");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_p0;
  logic             tc_p0;
  logic             ovf_p0;
  logic             step;
  logic             at_bound;

  // Loaded values above the top of the range are pulled down to MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Next count for one step; +1/-1 only happens strictly inside the range,
  // so no intermediate value ever leaves 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] c,
                                                input logic             dir);
    if (dir) begin
      if (c == MAXV) return (SATURATE == MODE_SAT) ? c : '0;
      return c + WIDTH'(1);
    end
    if (c == '0) return (SATURATE == MODE_SAT) ? c : MAXV;
    return c - WIDTH'(1);
  endfunction

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clear | load),
    .en    (counten),
    .tick  (step)
  );

  assign at_bound = up ? (count_p0 == MAXV) : (count_p0 == '0);

  // Count register with clear > load > step > hold; tc pulses after a bound step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_p0 <= '0;
      tc_p0    <= 1'b0;
      ovf_p0   <= 1'b0;
    end else if (clear) begin
      count_p0 <= '0;
      tc_p0    <= 1'b0;
      ovf_p0   <= 1'b0;
    end else if (load) begin
      count_p0 <= clamp_load(load_val);
      tc_p0    <= 1'b0;
    end else if (step) begin
      count_p0 <= step_val(count_p0, up);
      tc_p0    <= at_bound;
      ovf_p0   <= ovf_p0 | at_bound;
    end else begin
      tc_p0    <= 1'b0;
    end
  end

  assign count   = count_p0;
  assign tc      = tc_p0;
  assign ovf     = ovf_p0;
  assign at_max  = (count_p0 == MAXV);
  assign at_zero = (count_p0 == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: three counters (wrap/P1, saturate/P1, wrap/P3) share
// one stimulus stream and are compared every cycle against a reference model.
module tb_updown_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  typedef struct packed {
    int c;
    int p;
    bit tc;
    bit ovf;
  } mstate_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic         counten = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt   [3];
  logic         tc    [3];
  logic         ovf   [3];
  logic         amax  [3];
  logic         azero [3];

  mstate_t m [3];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .counten(counten), .up(up), .count(cnt[0]), .tc(tc[0]), .ovf(ovf[0]),
    .at_max(amax[0]), .at_zero(azero[0]));

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .counten(counten), .up(up), .count(cnt[1]), .tc(tc[1]), .ovf(ovf[1]),
    .at_max(amax[1]), .at_zero(azero[1]));

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(3)) u_presc (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .counten(counten), .up(up), .count(cnt[2]), .tc(tc[2]), .ovf(ovf[2]),
    .at_max(amax[2]), .at_zero(azero[2]));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: one clock edge of a counter over 0..MAXV.
  function automatic mstate_t mstep(input mstate_t s, input bit sat, input int ps,
                                    input bit clr, input bit ld, input int lv,
                                    input bit en, input bit dir);
    mstate_t n = s;
    bit bound;
    n.tc = 1'b0;
    if (clr) begin
      n = '0;
    end else if (ld) begin
      n.c = (lv > MAXV) ? MAXV : lv;
      n.p = 0;
    end else if (en) begin
      if (s.p == ps - 1) begin
        n.p   = 0;
        bound = dir ? (s.c == MAXV) : (s.c == 0);
        if (bound && sat)  n.c = s.c;
        else if (dir)      n.c = (s.c + 1) % (MAXV + 1);
        else               n.c = (s.c + MAXV) % (MAXV + 1);
        n.tc  = bound;
        n.ovf = s.ovf | bound;
      end else begin
        n.p = s.p + 1;
      end
    end
    return n;
  endfunction

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.count", i), cnt[i], m[i].c);
      chk($sformatf("d%0d.tc", i), tc[i], m[i].tc);
      chk($sformatf("d%0d.ovf", i), ovf[i], m[i].ovf);
      chk($sformatf("d%0d.at_max", i), amax[i], m[i].c == MAXV);
      chk($sformatf("d%0d.at_zero", i), azero[i], m[i].c == 0);
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], i == 1, (i == 2) ? 3 : 1, clear, load, int'(load_val), counten, up);
    #1;
    check_model();
  endtask

  // Reset pulse placed between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.d%0d.count", i), cnt[i], 0);
      chk($sformatf("rst.d%0d.tc", i), tc[i], 0);
      chk($sformatf("rst.d%0d.ovf", i), ovf[i], 0);
      m[i] = '0;
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    int enpat  [7] = '{1, 0, 1, 1, 1, 1, 1};
    int cntexp [7] = '{0, 0, 0, 1, 1, 1, 2};
    for (int i = 0; i < 3; i++) m[i] = '0;

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("por.d%0d.count", i), cnt[i], 0);
      chk($sformatf("por.d%0d.ovf", i), ovf[i], 0);
      chk($sformatf("por.d%0d.tc", i), tc[i], 0);
    end
    #2 reset = 1'b0;

    // Wrap up through MAX_VAL
    up = 1'b1; counten = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("wrap_up.count", cnt[0], (k + 1) % 10);
      chk("wrap_up.tc", tc[0], ((k + 1) % 10) == 0);
    end
    chk("wrap_up.ovf", ovf[0], 1);

    // Wrap down through zero
    counten = 1'b0; load = 1'b1; load_val = 4'd0;
    cycle();
    load = 1'b0; up = 1'b0; counten = 1'b1;
    cycle();
    chk("wrap_dn.count", cnt[0], 9);
    chk("wrap_dn.tc", tc[0], 1);
    cycle();
    chk("wrap_dn.count2", cnt[0], 8);
    chk("wrap_dn.tc2", tc[0], 0);

    // Saturate at MAX_VAL
    counten = 1'b0; load = 1'b1; load_val = 4'd8;
    cycle();
    load = 1'b0; up = 1'b1; counten = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("sat.count", cnt[1], 9);
      chk("sat.tc", tc[1], k > 0);
    end
    chk("sat.ovf", ovf[1], 1);

    // Prescale by 3 with a gap in the enable
    counten = 1'b0; clear = 1'b1;
    cycle();
    clear = 1'b0; up = 1'b1;
    for (int k = 0; k < 7; k++) begin
      counten = enpat[k][0];
      cycle();
      chk("presc.count", cnt[2], cntexp[k]);
    end

    // clear beats load; load clamps to MAX_VAL
    counten = 1'b0; load = 1'b1; clear = 1'b1; load_val = 4'd5;
    cycle();
    chk("clr_over_load", cnt[0], 0);
    clear = 1'b0; load_val = 4'd15;
    cycle();
    chk("load_clamp", cnt[0], 9);

    // Async reset with count=7, ovf=1
    load = 1'b0; up = 1'b1; counten = 1'b1;
    cycle();
    counten = 1'b0; load = 1'b1; load_val = 4'd7;
    cycle();
    load = 1'b0;
    chk("pre_rst.count", cnt[0], 7);
    chk("pre_rst.ovf", ovf[0], 1);
    async_reset();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      clear    = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
      counten  = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) == 1;
      cycle();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
